// File: rtl/usb_eps_arb_if.sv
// rtl/usb_eps_arb_if.sv - P/S requester and endpoint-status RAM signal bundle for usb_eps_arb
interface usb_eps_arb_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic [AW-1:0] p_addr_0;
    logic          p_read_0;
    logic          p_write_0;
    logic          p_zero_0;
    logic [DW-1:0] p_wrdata_0;
    logic [DW-1:0] p_rddata_3;

    logic          s_req_0;
    logic          s_we_0;
    logic          s_zero_0;
    logic [AW-1:0] s_addr_0;
    logic [DW-1:0] s_wrdata_0;
    logic          s_ack;
    logic [DW-1:0] s_rddata;

    logic [AW-1:0] ram_addr;
    logic          ram_rden;
    logic          ram_wren;
    logic [DW-1:0] ram_wrdata;
    logic [DW-1:0] ram_rddata;

    // arbiter side
    modport slave (
        input  p_addr_0, p_read_0, p_write_0, p_zero_0, p_wrdata_0,
        input  s_req_0, s_we_0, s_zero_0, s_addr_0, s_wrdata_0,
        input  ram_rddata,
        output p_rddata_3, s_ack, s_rddata,
        output ram_addr, ram_rden, ram_wren, ram_wrdata
    );

    // requesters and RAM side
    modport master (
        output p_addr_0, p_read_0, p_write_0, p_zero_0, p_wrdata_0,
        output s_req_0, s_we_0, s_zero_0, s_addr_0, s_wrdata_0,
        output ram_rddata,
        input  p_rddata_3, s_ack, s_rddata,
        input  ram_addr, ram_rden, ram_wren, ram_wrdata
    );
endinterface

// File: rtl/usb_eps_arb.sv
// rtl/usb_eps_arb.sv - endpoint-status RAM arbiter: priority P pipeline, S port on free cycles
module usb_eps_arb #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    usb_eps_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_PRD,
        TAG_SRD,
        TAG_SWR
    } tag_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DATA,
        S_ACK,
        S_GUARD
    } s_state_e;

    logic          p_cmd;
    logic          p_wr;
    logic          s_grant;

    logic [AW-1:0] st_addr_q,   st_addr_d;
    logic          st_rden_q,   st_rden_d;
    logic          st_wren_q,   st_wren_d;
    logic [DW-1:0] st_wrdata_q, st_wrdata_d;
    tag_e          st_tag_q,    st_tag_d;

    tag_e          rd_tag_q;
    logic [DW-1:0] p_rddata_q;
    logic [DW-1:0] s_rddata_q;

    s_state_e      s_state_q,   s_state_d;

    // Write or zero wins over read on the P port; S only sees cycles P leaves empty.
    always_comb begin
        p_cmd   = bus.p_read_0 | bus.p_write_0 | bus.p_zero_0;
        p_wr    = bus.p_write_0 | bus.p_zero_0;
        s_grant = !p_cmd && (s_state_q == S_IDLE) && bus.s_req_0;
    end

    always_comb begin
        st_addr_d   = '0;
        st_rden_d   = 1'b0;
        st_wren_d   = 1'b0;
        st_wrdata_d = '0;
        st_tag_d    = TAG_NONE;
        if (p_cmd) begin
            st_addr_d = bus.p_addr_0;
            if (p_wr) begin
                st_wren_d   = 1'b1;
                st_wrdata_d = bus.p_zero_0 ? '0 : bus.p_wrdata_0;
            end else begin
                st_rden_d = 1'b1;
                st_tag_d  = TAG_PRD;
            end
        end else if (s_grant) begin
            st_addr_d = bus.s_addr_0;
            if (bus.s_zero_0 || bus.s_we_0) begin
                st_wren_d   = 1'b1;
                st_wrdata_d = bus.s_zero_0 ? '0 : bus.s_wrdata_0;
                st_tag_d    = TAG_SWR;
            end else begin
                st_rden_d = 1'b1;
                st_tag_d  = TAG_SRD;
            end
        end
    end

    always_comb begin
        s_state_d = s_state_q;
        case (s_state_q)
            S_IDLE:  if (s_grant) s_state_d = S_ISSUE;
            S_ISSUE: s_state_d = S_DATA;
            S_DATA:  s_state_d = S_ACK;
            S_ACK:   s_state_d = S_GUARD;
            S_GUARD: s_state_d = S_IDLE;
            default: s_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_state_q <= S_IDLE;
        end else begin
            s_state_q <= s_state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_addr_q   <= '0;
            st_rden_q   <= 1'b0;
            st_wren_q   <= 1'b0;
            st_wrdata_q <= '0;
            st_tag_q    <= TAG_NONE;
        end else begin
            st_addr_q   <= st_addr_d;
            st_rden_q   <= st_rden_d;
            st_wren_q   <= st_wren_d;
            st_wrdata_q <= st_wrdata_d;
            st_tag_q    <= st_tag_d;
        end
    end

    // The tag follows the read into the RAM's data cycle to steer the capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_tag_q   <= TAG_NONE;
            p_rddata_q <= '0;
            s_rddata_q <= '0;
        end else begin
            rd_tag_q <= st_tag_q;
            if (rd_tag_q == TAG_PRD) begin
                p_rddata_q <= bus.ram_rddata;
            end
            if (rd_tag_q == TAG_SRD) begin
                s_rddata_q <= bus.ram_rddata;
            end
        end
    end

    assign bus.ram_addr   = st_addr_q;
    assign bus.ram_rden   = st_rden_q;
    assign bus.ram_wren   = st_wren_q;
    assign bus.ram_wrdata = st_wrdata_q;
    assign bus.p_rddata_3 = p_rddata_q;
    assign bus.s_rddata   = s_rddata_q;
    assign bus.s_ack      = (s_state_q == S_ACK);

endmodule

// File: tb/tb_usb_eps_arb.sv
// tb/tb_usb_eps_arb.sv - directed and randomized bench for usb_eps_arb with an issue-order memory model
module tb_usb_eps_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_eps_arb_if #(.AW(8), .DW(16)) bus ();

    usb_eps_arb #(.AW(8), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single-port synchronous RAM, one-cycle read latency
    logic [15:0] ram_mem [0:255];
    always @(posedge clk) begin
        if (bus.ram_wren) ram_mem[bus.ram_addr] <= bus.ram_wrdata;
        if (bus.ram_rden) bus.ram_rddata <= ram_mem[bus.ram_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;
    int k        = 0;

    // Reference: memory updated in issue order, plus expected events keyed by cycle number
    logic [15:0] shadow [0:255];
    bit          e_rd   [0:63];
    bit          e_wr   [0:63];
    logic [7:0]  e_addr [0:63];
    logic [15:0] e_data [0:63];
    bit          pu_vld [0:63];
    logic [15:0] pu_val [0:63];
    logic [15:0] exp_p;
    logic [15:0] exp_s;
    int          s_next_ok;
    int          s_ack_cyc;
    int          s_grant_cyc;
    bit          s_is_rd;
    bit          s_granted;
    logic [15:0] s_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) begin
            e_rd[i] = 1'b0; e_wr[i] = 1'b0; e_addr[i] = '0; e_data[i] = '0;
            pu_vld[i] = 1'b0; pu_val[i] = '0;
        end
        exp_p = '0;
        exp_s = '0;
        s_ack_cyc = -1;
        s_next_ok = k;
    endtask

    // Check cycle k outputs, apply cycle k inputs, predict, advance one clock.
    task automatic cyc(input bit rd, input bit wr, input bit z,
                       input logic [7:0] a, input logic [15:0] d);
        int i0, i1, i3;
        bit ack_exp;
        i0 = k % 64;
        i1 = (k + 1) % 64;
        i3 = (k + 3) % 64;

        chk("ram_rden", 32'(bus.ram_rden), 32'(e_rd[i0]));
        chk("ram_wren", 32'(bus.ram_wren), 32'(e_wr[i0]));
        if (e_rd[i0] || e_wr[i0]) chk("ram_addr", 32'(bus.ram_addr), 32'(e_addr[i0]));
        if (e_wr[i0]) chk("ram_wrdata", 32'(bus.ram_wrdata), 32'(e_data[i0]));
        if (pu_vld[i0]) begin
            exp_p = pu_val[i0];
            pu_vld[i0] = 1'b0;
        end
        chk("p_rddata_3", 32'(bus.p_rddata_3), 32'(exp_p));
        ack_exp = (k == s_ack_cyc);
        if (ack_exp && s_is_rd) exp_s = s_val;
        chk("s_ack", 32'(bus.s_ack), 32'(ack_exp));
        chk("s_rddata", 32'(bus.s_rddata), 32'(exp_s));

        bus.p_read_0   = rd;
        bus.p_write_0  = wr;
        bus.p_zero_0   = z;
        bus.p_addr_0   = a;
        bus.p_wrdata_0 = d;

        e_rd[i1] = 1'b0; e_wr[i1] = 1'b0; e_addr[i1] = '0; e_data[i1] = '0;
        if (rd || wr || z) begin
            e_addr[i1] = a;
            if (wr || z) begin
                e_wr[i1]   = 1'b1;
                e_data[i1] = z ? 16'h0000 : d;
                shadow[a]  = e_data[i1];
            end else begin
                e_rd[i1]   = 1'b1;
                pu_vld[i3] = 1'b1;
                pu_val[i3] = shadow[a];
            end
        end else if (bus.s_req_0 && k >= s_next_ok) begin
            s_next_ok   = k + 5;
            s_ack_cyc   = k + 3;
            s_grant_cyc = k;
            s_granted   = 1'b1;
            e_addr[i1]  = bus.s_addr_0;
            if (bus.s_zero_0 || bus.s_we_0) begin
                e_wr[i1]   = 1'b1;
                e_data[i1] = bus.s_zero_0 ? 16'h0000 : bus.s_wrdata_0;
                shadow[bus.s_addr_0] = e_data[i1];
                s_is_rd    = 1'b0;
            end else begin
                e_rd[i1] = 1'b1;
                s_is_rd  = 1'b1;
                s_val    = shadow[bus.s_addr_0];
            end
        end

        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ack"},      32'(bus.s_ack),      32'h0);
        chk({tag, "_ram_rden"},   32'(bus.ram_rden),   32'h0);
        chk({tag, "_ram_wren"},   32'(bus.ram_wren),   32'h0);
        chk({tag, "_ram_addr"},   32'(bus.ram_addr),   32'h0);
        chk({tag, "_ram_wrdata"}, 32'(bus.ram_wrdata), 32'h0);
        chk({tag, "_p_rddata_3"}, 32'(bus.p_rddata_3), 32'h0);
        chk({tag, "_s_rddata"},   32'(bus.s_rddata),   32'h0);
    endtask

    initial begin
        logic [15:0] v;
        bit rd, wr, z;
        int p_run;

        bus.p_addr_0 = '0; bus.p_read_0 = 1'b0; bus.p_write_0 = 1'b0;
        bus.p_zero_0 = 1'b0; bus.p_wrdata_0 = '0;
        bus.s_req_0 = 1'b0; bus.s_we_0 = 1'b0; bus.s_zero_0 = 1'b0;
        bus.s_addr_0 = '0; bus.s_wrdata_0 = '0;
        s_granted = 1'b0; s_is_rd = 1'b0; s_val = '0; s_grant_cyc = -10;
        clear_model();

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        k = 0;
        clear_model();

        // Preload every address so the shadow is fully defined
        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            if (i == 8'h12) v = 16'hBEEF;
            if (i == 8'h05) v = 16'hA5A5;
            cyc(1'b0, 1'b1, 1'b0, 8'(i), v);
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);

        // P read pipeline
        cyc(1'b1, 1'b0, 1'b0, 8'h12, 16'h0000);
        chk("t1_rden", 32'(bus.ram_rden), 32'h1);
        chk("t1_addr", 32'(bus.ram_addr), 32'h12);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t1_p_rddata", 32'(bus.p_rddata_3), 32'hBEEF);
        chk("t1_s_rddata", 32'(bus.s_rddata), 32'h0);

        // Back-to-back P write / read / zero
        cyc(1'b0, 1'b1, 1'b0, 8'h20, 16'h1234);
        chk("t2_c1_wren", 32'(bus.ram_wren), 32'h1);
        chk("t2_c1_data", 32'(bus.ram_wrdata), 32'h1234);
        cyc(1'b1, 1'b0, 1'b0, 8'h20, 16'h0000);
        chk("t2_c2_rden", 32'(bus.ram_rden), 32'h1);
        chk("t2_c2_addr", 32'(bus.ram_addr), 32'h20);
        cyc(1'b0, 1'b0, 1'b1, 8'h21, 16'hFFFF);
        chk("t2_c3_wren", 32'(bus.ram_wren), 32'h1);
        chk("t2_c3_data", 32'(bus.ram_wrdata), 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 8'h21, 16'h0000);
        chk("t2_c4_p_rddata", 32'(bus.p_rddata_3), 32'h1234);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t2_zero_readback", 32'(bus.p_rddata_3), 32'h0);

        // S read uncontended, request held through cycle 4
        bus.s_req_0 = 1'b1; bus.s_we_0 = 1'b0; bus.s_zero_0 = 1'b0;
        bus.s_addr_0 = 8'h05; bus.s_wrdata_0 = 16'h0000;
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t3_c1_rden", 32'(bus.ram_rden), 32'h1);
        chk("t3_c1_addr", 32'(bus.ram_addr), 32'h05);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t3_c2_ack", 32'(bus.s_ack), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t3_c3_ack", 32'(bus.s_ack), 32'h1);
        chk("t3_c3_rddata", 32'(bus.s_rddata), 32'hA5A5);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t3_c4_ack", 32'(bus.s_ack), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t3_c5_rden", 32'(bus.ram_rden), 32'h0);
        chk("t3_c5_wren", 32'(bus.ram_wren), 32'h0);
        bus.s_req_0 = 1'b0;

        // Contention: S write held while P occupies cycles 0-2
        bus.s_req_0 = 1'b1; bus.s_we_0 = 1'b1; bus.s_zero_0 = 1'b0;
        bus.s_addr_0 = 8'h30; bus.s_wrdata_0 = 16'h5555;
        cyc(1'b1, 1'b0, 1'b0, 8'h12, 16'h0000);
        chk("t4_c1_addr", 32'(bus.ram_addr), 32'h12);
        cyc(1'b0, 1'b1, 1'b0, 8'h31, 16'h7777);
        chk("t4_c2_addr", 32'(bus.ram_addr), 32'h31);
        cyc(1'b1, 1'b0, 1'b0, 8'h30, 16'h0000);
        chk("t4_c3_rden", 32'(bus.ram_rden), 32'h1);
        chk("t4_c3_p_rddata", 32'(bus.p_rddata_3), 32'hBEEF);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t4_c4_wren", 32'(bus.ram_wren), 32'h1);
        chk("t4_c4_addr", 32'(bus.ram_addr), 32'h30);
        chk("t4_c4_data", 32'(bus.ram_wrdata), 32'h5555);
        bus.s_wrdata_0 = 16'h0000; bus.s_addr_0 = 8'h31;
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t4_c6_ack", 32'(bus.s_ack), 32'h1);
        bus.s_req_0 = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 8'h30, 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 8'h31, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t4_rb_30", 32'(bus.p_rddata_3), 32'h5555);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t4_rb_31", 32'(bus.p_rddata_3), 32'h7777);

        // Read+write precedence on P, zero precedence on S
        cyc(1'b1, 1'b1, 1'b0, 8'h40, 16'h9999);
        chk("t5_wren", 32'(bus.ram_wren), 32'h1);
        chk("t5_rden", 32'(bus.ram_rden), 32'h0);
        chk("t5_data", 32'(bus.ram_wrdata), 32'h9999);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t5_p_hold", 32'(bus.p_rddata_3), 32'h7777);
        bus.s_req_0 = 1'b1; bus.s_we_0 = 1'b0; bus.s_zero_0 = 1'b1;
        bus.s_addr_0 = 8'h41; bus.s_wrdata_0 = 16'hFFFF;
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t5_s_wren", 32'(bus.ram_wren), 32'h1);
        chk("t5_s_data", 32'(bus.ram_wrdata), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t5_s_ack", 32'(bus.s_ack), 32'h1);
        bus.s_req_0 = 1'b0; bus.s_zero_0 = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 8'h40, 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 8'h41, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t5_rb_40", 32'(bus.p_rddata_3), 32'h9999);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t5_rb_41", 32'(bus.p_rddata_3), 32'h0);

        // Reset in cycle 2 of an S read
        bus.s_req_0 = 1'b1; bus.s_we_0 = 1'b0; bus.s_addr_0 = 8'h12;
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        bus.s_addr_0 = 8'h20;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            chk("midrst_no_ack", 32'(bus.s_ack), 32'h0);
        end
        rst = 1'b0;
        clear_model();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t6_c1_rden", 32'(bus.ram_rden), 32'h1);
        chk("t6_c1_addr", 32'(bus.ram_addr), 32'h20);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("t6_c3_ack", 32'(bus.s_ack), 32'h1);
        chk("t6_c3_rddata", 32'(bus.s_rddata), 32'h1234);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        bus.s_req_0 = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);

        // Randomized traffic: P bursts of at most three, S requests held until after ack
        p_run = 0;
        for (int n = 0; n < 3000; n++) begin
            if (bus.s_req_0 && s_granted && k >= s_grant_cyc + 5) bus.s_req_0 = 1'b0;
            if (!bus.s_req_0 && $urandom_range(0, 3) == 0) begin
                bus.s_req_0    = 1'b1;
                bus.s_we_0     = ($urandom_range(0, 1) == 1);
                bus.s_zero_0   = ($urandom_range(0, 3) == 0);
                bus.s_addr_0   = 8'($urandom_range(0, 15));
                bus.s_wrdata_0 = 16'($urandom);
                s_granted      = 1'b0;
            end else if (bus.s_req_0 && s_granted) begin
                bus.s_we_0     = ($urandom_range(0, 1) == 1);
                bus.s_zero_0   = ($urandom_range(0, 1) == 1);
                bus.s_addr_0   = 8'($urandom_range(0, 255));
                bus.s_wrdata_0 = 16'($urandom);
            end
            if (p_run < 3 && $urandom_range(0, 1) == 1) begin
                rd = ($urandom_range(0, 1) == 1);
                wr = ($urandom_range(0, 2) == 0);
                z  = ($urandom_range(0, 3) == 0);
                if (!(rd || wr || z)) rd = 1'b1;
                p_run++;
            end else begin
                rd = 1'b0; wr = 1'b0; z = 1'b0;
                p_run = 0;
            end
            cyc(rd, wr, z, 8'($urandom_range(0, 15)), 16'($urandom));
        end
        bus.s_req_0 = 1'b0;
        for (int n = 0; n < 8; n++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
